// File: rtl/sbit_expander.sv
// sbit_expander: VFAT S-bit front-end ahead of cluster_packer.
// It registers each BX of S-bits and applies the per-VFAT mask. Hits are
// stretched over STRETCH extra BX. Each S-bit is then expanded onto
// OUT_WIDTH/IN_WIDTH strips according to the mapping mode.
// Optional per-VFAT hit counters are built when SBIT_EXPANDER_HIT_COUNTERS_EN
// is defined; otherwise cnt_value is tied to zero.
module sbit_expander #(
  parameter int NUM_VFATS = 24,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 64,
  parameter int STRETCH   = 0,
  parameter int STRETCH_W = 3
) (
  input  logic                           clock4x,
  input  logic                           global_reset_n,
  input  logic [NUM_VFATS*IN_WIDTH-1:0]  sbits_in,
  input  logic                           sbits_valid,
  input  logic [NUM_VFATS-1:0]           vfat_mask,
  input  logic [1:0]                     mode,
  output logic [NUM_VFATS*OUT_WIDTH-1:0] sbits_out,
  output logic                           sbits_out_valid,
  output logic [NUM_VFATS-1:0]           active_vfats,
  input  logic [4:0]                     cnt_sel,
  input  logic                           cnt_clear,
  output logic [15:0]                    cnt_value
);

  localparam int EXPAND     = OUT_WIDTH / IN_WIDTH;
  localparam int CENTER_IDX = EXPAND / 2;
  localparam int NIN        = NUM_VFATS * IN_WIDTH;
  localparam int NOUT       = NUM_VFATS * OUT_WIDTH;
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH);

  typedef enum logic [1:0] {
    MODE_REPLICATE = 2'd0,
    MODE_CENTER    = 2'd1,
    MODE_FIRST     = 2'd2,
    MODE_OFF       = 2'd3
  } mode_t;

  // Expansion ratio must be whole and the stretch counter must hold STRETCH.
  generate
    if ((OUT_WIDTH % IN_WIDTH) != 0) begin : g_bad_ratio
      $error("sbit_expander: OUT_WIDTH must be a multiple of IN_WIDTH");
    end
    if ((1 << STRETCH_W) <= STRETCH) begin : g_bad_stretch_w
      $error("sbit_expander: STRETCH_W too narrow for STRETCH");
    end
  endgenerate

  logic [NIN-1:0]           raw;
  logic [NIN-1:0]           stretched_next;
  logic [NIN-1:0]           stretched_reg;
  logic [STRETCH_W-1:0]     stretch_cnt_reg [NIN];
  mode_t                    mode_reg;
  logic                     valid_d1_reg;
  logic [NOUT-1:0]          expanded;
  logic [NUM_VFATS-1:0]     active_next;
  logic [NOUT-1:0]          sbits_out_reg;
  logic                     out_valid_reg;
  logic [NUM_VFATS-1:0]     active_reg;

  // Per S-bit masking and stretch tail tracking.
  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_bit
      localparam int V = gi / IN_WIDTH;
      assign raw[gi] = sbits_in[gi] & ~vfat_mask[V];
      // A masked VFAT drops its tail on the same strobe.
      assign stretched_next[gi] = raw[gi] |
                                  ((stretch_cnt_reg[gi] != '0) & ~vfat_mask[V]);

      // Stretch counter: reload on hit, count down on quiet strobes.
      always_ff @(posedge clock4x) begin
        if (!global_reset_n) begin
          stretch_cnt_reg[gi] <= '0;
        end else if (sbits_valid) begin
          if (vfat_mask[V])
            stretch_cnt_reg[gi] <= '0;
          else if (raw[gi])
            stretch_cnt_reg[gi] <= STRETCH_LOAD;
          else if (stretch_cnt_reg[gi] != '0)
            stretch_cnt_reg[gi] <= stretch_cnt_reg[gi] - STRETCH_W'(1);
        end
      end
    end
  endgenerate

  // Stage 1: capture the stretched S-bits and the mode of this BX.
  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      stretched_reg <= '0;
      mode_reg      <= MODE_REPLICATE;
      valid_d1_reg  <= 1'b0;
    end else begin
      valid_d1_reg <= sbits_valid;
      if (sbits_valid) begin
        stretched_reg <= stretched_next;
        mode_reg      <= mode_t'(mode);
      end
    end
  end

  // Strip mapping: each S-bit drives one, all or none of its EXPAND strips.
  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_exp_bit
      for (genvar gj = 0; gj < EXPAND; gj++) begin : g_exp_strip
        assign expanded[gi*EXPAND + gj] = stretched_reg[gi] &
            ((mode_reg == MODE_REPLICATE) ||
             ((mode_reg == MODE_CENTER) && (gj == CENTER_IDX)) ||
             ((mode_reg == MODE_FIRST)  && (gj == 0)));
      end
    end
    for (genvar gi = 0; gi < NUM_VFATS; gi++) begin : g_active
      assign active_next[gi] = |expanded[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // Stage 2: register the expanded strips; hold them between strobes.
  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      sbits_out_reg <= '0;
      active_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= valid_d1_reg;
      if (valid_d1_reg) begin
        sbits_out_reg <= expanded;
        active_reg    <= active_next;
      end
    end
  end

  assign sbits_out       = sbits_out_reg;
  assign sbits_out_valid = out_valid_reg;
  assign active_vfats    = active_reg;

`ifdef SBIT_EXPANDER_HIT_COUNTERS_EN
  logic [15:0] hit_cnt_reg [NUM_VFATS];
  logic [15:0] sel_value;
  logic [15:0] cnt_value_reg;

  generate
    for (genvar gi = 0; gi < NUM_VFATS; gi++) begin : g_hit_cnt
      // Saturating count of strobes with any unmasked hit; clear wins.
      always_ff @(posedge clock4x) begin
        if (!global_reset_n || cnt_clear)
          hit_cnt_reg[gi] <= '0;
        else if (sbits_valid && (|raw[gi*IN_WIDTH +: IN_WIDTH]) &&
                 (hit_cnt_reg[gi] != 16'hFFFF))
          hit_cnt_reg[gi] <= hit_cnt_reg[gi] + 16'd1;
      end
    end
  endgenerate

  // Out-of-range selects read as zero.
  always_comb begin
    sel_value = '0;
    if (int'(cnt_sel) < NUM_VFATS)
      sel_value = hit_cnt_reg[cnt_sel];
  end

  // Registered readout of the selected counter.
  always_ff @(posedge clock4x) begin
    if (!global_reset_n)
      cnt_value_reg <= '0;
    else
      cnt_value_reg <= sel_value;
  end

  assign cnt_value = cnt_value_reg;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{cnt_sel, cnt_clear};
  assign cnt_value = 16'd0;
`endif

endmodule

// File: tb/tb_sbit_expander.sv
// Testbench for sbit_expander (STRETCH=2). It runs table vectors, hand
// sequences for reset, stretch, back-to-back strobes and mid-stream reset,
// and then randomised strobes checked against a reference model.
// Counter checks follow SBIT_EXPANDER_HIT_COUNTERS_EN.
module tb_sbit_expander;
  localparam int NV  = 24;
  localparam int IW  = 8;
  localparam int OW  = 64;
  localparam int EXP = OW / IW;
  localparam int STR = 2;
  localparam int IBW = NV * IW;
  localparam int OBW = NV * OW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IBW-1:0]  sbits_in;
  logic            sbits_valid;
  logic [NV-1:0]   vfat_mask;
  logic [1:0]      mode;
  logic [OBW-1:0]  sbits_out;
  logic            sbits_out_valid;
  logic [NV-1:0]   active_vfats;
  logic [4:0]      cnt_sel;
  logic            cnt_clear;
  logic [15:0]     cnt_value;

  always #5 clk = ~clk;

  sbit_expander #(
    .NUM_VFATS(NV), .IN_WIDTH(IW), .OUT_WIDTH(OW), .STRETCH(STR), .STRETCH_W(3)
  ) dut (
    .clock4x(clk), .global_reset_n(rst_n), .sbits_in(sbits_in),
    .sbits_valid(sbits_valid), .vfat_mask(vfat_mask), .mode(mode),
    .sbits_out(sbits_out), .sbits_out_valid(sbits_out_valid),
    .active_vfats(active_vfats), .cnt_sel(cnt_sel), .cnt_clear(cnt_clear),
    .cnt_value(cnt_value)
  );

  typedef struct {
    int             due;
    logic [OBW-1:0] bus;
  } exp_t;

  typedef struct {
    int          vfat;
    logic [7:0]  din;
    logic [1:0]  md;
    bit          msk;
    logic [63:0] slice;
  } vec_t;

  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  bit             verbose = 1'b1;
  exp_t           q[$];
  logic [OBW-1:0] last_out = '0;
  int             last_hit[IBW];
  int             strobe_idx = 0;
  int             mcnt[NV];
  vec_t           tbl[10];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, expv);
    end
  endfunction

  function automatic void chk_bus(string name, logic [OBW-1:0] act, logic [OBW-1:0] expv);
    checks++;
    if (act !== expv) begin
      int bad = 0;
      failures++;
      for (int v = NV - 1; v >= 0; v--)
        if (act[v*OW +: OW] !== expv[v*OW +: OW]) bad = v;
      $display("FAIL %s cyc=%0d vfat=%0d got=%h exp=%h", name, cyc, bad,
               act[bad*OW +: OW], expv[bad*OW +: OW]);
    end
  endfunction

  function automatic logic [NV-1:0] or_slices(logic [OBW-1:0] bus);
    logic [NV-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = (bus[v*OW +: OW] != '0);
    return r;
  endfunction

  // A bit is lit while fewer than STR+1 strobes have passed since its last hit.
  function automatic logic [OBW-1:0] model_strobe(logic [IBW-1:0] din,
                                                 logic [NV-1:0] msk, logic [1:0] md);
    logic [OBW-1:0] r;
    r = '0;
    strobe_idx++;
    for (int i = 0; i < IBW; i++) begin
      if (msk[i / IW]) last_hit[i] = -1000;
      else if (din[i]) last_hit[i] = strobe_idx;
    end
    for (int s = 0; s < OBW; s++) begin
      int  bi;
      int  off;
      bit  st;
      bi  = s / EXP;
      off = s % EXP;
      st  = (strobe_idx - last_hit[bi]) <= STR;
      case (md)
        2'd0:    r[s] = st;
        2'd1:    r[s] = st && (off == EXP / 2);
        2'd2:    r[s] = st && (off == 0);
        default: r[s] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic void model_reset();
    strobe_idx = 0;
    for (int i = 0; i < IBW; i++) last_hit[i] = -1000;
  endfunction

  // Advance one clock and check every output for the new cycle.
  task automatic tick();
    bit in_rst;
    int nxt_cnt;
    in_rst  = !rst_n;
    nxt_cnt = (int'(cnt_sel) < NV) ? mcnt[cnt_sel] : 0;
    if (in_rst) begin
      nxt_cnt = 0;
      for (int v = 0; v < NV; v++) mcnt[v] = 0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (cnt_clear) mcnt[v] = 0;
        else if (sbits_valid && !vfat_mask[v] && (sbits_in[v*IW +: IW] != '0) &&
                 mcnt[v] < 65535)
          mcnt[v]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
`ifdef SBIT_EXPANDER_HIT_COUNTERS_EN
    chk("cnt_value", 64'(cnt_value), 64'(nxt_cnt));
`else
    chk("cnt_value", 64'(cnt_value), 64'd0);
`endif
    if (in_rst) begin
      q.delete();
      last_out = '0;
      chk("rst_valid", 64'(sbits_out_valid), 64'd0);
      chk_bus("rst_sbits_out", sbits_out, '0);
      chk("rst_active", 64'(active_vfats), 64'd0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      last_out = q[0].bus;
      void'(q.pop_front());
      chk("out_valid", 64'(sbits_out_valid), 64'd1);
      chk_bus("sbits_out", sbits_out, last_out);
      chk("active_vfats", 64'(active_vfats), 64'(or_slices(last_out)));
      if (verbose) $display("txn cyc=%0d active=%h", cyc, active_vfats);
    end else begin
      chk("idle_valid", 64'(sbits_out_valid), 64'd0);
      chk_bus("hold_sbits_out", sbits_out, last_out);
      chk("hold_active", 64'(active_vfats), 64'(or_slices(last_out)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe_drive(input logic [IBW-1:0] din, input logic [NV-1:0] msk,
                              input logic [1:0] md, input bit use_exp,
                              input logic [OBW-1:0] expv);
    logic [OBW-1:0] m;
    exp_t e;
    sbits_in    = din;
    vfat_mask   = msk;
    mode        = md;
    sbits_valid = 1'b1;
    m = model_strobe(din, msk, md);
    e.due = cyc + 2;
    e.bus = use_exp ? expv : m;
    if (rst_n) q.push_back(e);
    tick();
    sbits_valid = 1'b0;
    sbits_in    = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    sbits_valid = 1'b1;
    sbits_in    = '1;
    idle(n);
    rst_n       = 1'b1;
    sbits_valid = 1'b0;
    sbits_in    = '0;
    vfat_mask   = '0;
    model_reset();
  endtask

  initial begin
    logic [IBW-1:0] din;
    logic [NV-1:0]  msk;
    logic [OBW-1:0] expv;

    tbl[0] = '{0, 8'h81, 2'd0, 1'b0, 64'hFF00_0000_0000_00FF};
    tbl[1] = '{5, 8'h08, 2'd1, 1'b0, 64'h0000_0000_1000_0000};
    tbl[2] = '{5, 8'h08, 2'd2, 1'b0, 64'h0000_0000_0100_0000};
    tbl[3] = '{5, 8'hFF, 2'd3, 1'b0, 64'h0};
    tbl[4] = '{9, 8'hFF, 2'd0, 1'b1, 64'h0};
    tbl[5] = '{1, 8'h01, 2'd1, 1'b0, 64'h0000_0000_0000_0010};
    tbl[6] = '{23, 8'h80, 2'd2, 1'b0, 64'h0100_0000_0000_0000};
    tbl[7] = '{12, 8'hFF, 2'd1, 1'b0, 64'h1010_1010_1010_1010};
    tbl[8] = '{3, 8'h55, 2'd2, 1'b0, 64'h0001_0001_0001_0001};
    tbl[9] = '{17, 8'h3C, 2'd0, 1'b0, 64'h0000_FFFF_FFFF_0000};

    rst_n = 1'b0; sbits_in = '0; sbits_valid = 1'b0; vfat_mask = '0;
    mode = 2'd0; cnt_sel = 5'd0; cnt_clear = 1'b0;
    for (int v = 0; v < NV; v++) mcnt[v] = 0;
    model_reset();

    // Reset held 3 cycles with strobes and all-ones data, then one quiet cycle.
    do_reset(3);
    tick();
    $display("txn reset_release cyc=%0d sbits_out_valid=%0d", cyc, sbits_out_valid);

    // Table vectors, each from a clean reset.
    for (int k = 0; k < 10; k++) begin
      do_reset(1);
      din = '0; msk = '0; expv = '0;
      din[tbl[k].vfat*IW +: IW]  = tbl[k].din;
      msk[tbl[k].vfat]           = tbl[k].msk;
      expv[tbl[k].vfat*OW +: OW] = tbl[k].slice;
      strobe_drive(din, msk, tbl[k].md, 1'b1, expv);
      idle(3);
      $display("txn vec=%0d vfat=%0d din=%h mode=%0d", k, tbl[k].vfat, tbl[k].din, tbl[k].md);
    end

    // Stretch: one hit, three quiet strobes -> lit, lit, lit, clear.
    do_reset(1);
    din = '0; din[2*IW] = 1'b1;
    expv = '0; expv[2*OW +: OW] = 64'hFF;
    strobe_drive(din, '0, 2'd0, 1'b1, expv);
    idle(3);
    strobe_drive('0, '0, 2'd0, 1'b1, expv);
    idle(3);
    strobe_drive('0, '0, 2'd0, 1'b1, expv);
    idle(3);
    strobe_drive('0, '0, 2'd0, 1'b1, '0);
    idle(3);
    $display("txn stretch_tail cyc=%0d", cyc);

    // Mask on the second strobe kills the tail at that output.
    do_reset(1);
    strobe_drive(din, '0, 2'd0, 1'b1, expv);
    idle(3);
    msk = '0; msk[2] = 1'b1;
    strobe_drive('0, msk, 2'd0, 1'b1, '0);
    idle(3);
    strobe_drive('0, '0, 2'd0, 1'b1, '0);
    idle(3);
    $display("txn stretch_mask cyc=%0d", cyc);

    // Back-to-back strobes with distinct data and modes.
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      din = '0;
      din[(k*5)*IW +: IW] = 8'(8'h11 << k);
      strobe_drive(din, '0, 2'(k), 1'b0, '0);
    end
    idle(4);
    $display("txn back_to_back cyc=%0d", cyc);

    // Reset right behind a strobe discards it.
    do_reset(1);
    din = '1;
    strobe_drive(din, '0, 2'd0, 1'b0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    idle(3);
    $display("txn midstream_reset cyc=%0d", cyc);

    // Randomised strobes with random gaps, masks, modes and counter controls.
    do_reset(1);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < IBW; i += 32) din[i +: 32] = $urandom & $urandom & $urandom;
      for (int v = 0; v < NV; v++) msk[v] = ($urandom_range(0, 7) == 0);
      cnt_sel   = 5'($urandom_range(0, 31));
      cnt_clear = ($urandom_range(0, 19) == 0);
      strobe_drive(din, msk, 2'($urandom_range(0, 3)), 1'b0, '0);
      cnt_clear = 1'b0;
      idle($urandom_range(0, 4));
    end
    idle(4);

`ifdef SBIT_EXPANDER_HIT_COUNTERS_EN
    // Saturation, clear and masked readout of the hit counters.
    do_reset(1);
    verbose = 1'b0;
    cnt_sel = 5'd7;
    din = '0; din[7*IW] = 1'b1;
    for (int k = 0; k < 65540; k++) strobe_drive(din, '0, 2'd0, 1'b0, '0);
    verbose = 1'b1;
    idle(3);
    chk("cnt_saturated", 64'(cnt_value), 64'hFFFF);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    tick();
    chk("cnt_cleared", 64'(cnt_value), 64'h0);
    msk = '0; msk[7] = 1'b1;
    din = '0; din[7*IW +: IW] = 8'hFF;
    for (int k = 0; k < 3; k++) strobe_drive(din, msk, 2'd0, 1'b0, '0);
    idle(3);
    chk("cnt_masked", 64'(cnt_value), 64'h0);
    cnt_sel = 5'd30;
    idle(2);
    chk("cnt_sel_oor", 64'(cnt_value), 64'h0);
    $display("txn hit_counters cyc=%0d", cyc);
`endif

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
